// File: rtl/aemb2_wb_sched_pkg.sv
// Shared definitions for the AEMB2 instruction/data Wishbone scheduler:
// arbiter state encoding, default parameters and the request helper.
package aemb2_wb_sched_pkg;

  localparam int AW_DEF  = 14;
  localparam int TMO_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } sched_state_e;

  typedef logic [7:0] tmo_cnt_t;

  // A master is requesting only while both cycle and strobe are high
  function automatic logic f_req(input logic cyc, input logic stb);
    return cyc & stb;
  endfunction

endpackage

// File: rtl/aemb2_wb_sched_if.sv
// One Wishbone-style port bundle; signal names follow the master side, so
// a master drives the *_o members and a slave answers on the *_i members.
interface aemb2_wb_sched_if
  import aemb2_wb_sched_pkg::*;
#(
  parameter int AW = AW_DEF
);

  logic [AW-1:2] adr_o;
  logic [3:0]    sel_o;
  logic          stb_o;
  logic          wre_o;
  logic          cyc_o;
  logic [31:0]   dat_o;
  logic [31:0]   dat_i;
  logic          ack_i;
  logic          err_i;

  modport master (
    output adr_o, sel_o, stb_o, wre_o, cyc_o, dat_o,
    input  dat_i, ack_i, err_i
  );

  modport slave (
    input  adr_o, sel_o, stb_o, wre_o, cyc_o, dat_o,
    output dat_i, ack_i, err_i
  );

endinterface

// File: rtl/aemb2_wb_sched_tmo.sv
// Bus watchdog: counts strobe cycles left unacknowledged and flags when the
// count has reached TMO-1, i.e. the current strobe cycle is the TMO-th.
module aemb2_wb_tmo
  import aemb2_wb_sched_pkg::*;
#(
  parameter int TMO = TMO_DEF
) (
  input  logic sys_clk_i,
  input  logic sys_rst_i,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  tmo_cnt_t r_cnt;

  // Wait counter; clear has priority over increment
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_cnt <= 8'h00;
    end else if (clr) begin
      r_cnt <= 8'h00;
    end else if (inc) begin
      r_cnt <= r_cnt + 8'h01;
    end
  end

  assign expired = (r_cnt == tmo_cnt_t'(TMO - 1));

endmodule

// File: rtl/aemb2_wb.sv
// Round-robin scheduler sharing one RAM port between the AEMB2 fetch (iwb)
// and data (dwb) masters, with bus lock on cyc and a watchdog bus error.
module aemb2_wb_sched
  import aemb2_wb_sched_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  aemb2_wb_sched_if.slave  iwb,
  aemb2_wb_sched_if.slave  dwb,
  aemb2_wb_sched_if.master mwb,
  output logic             tmo_flg_o
);

  sched_state_e  r_state;
  sched_state_e  w_state_nxt;
  logic          r_last_i;
  logic          w_last_i_nxt;
  logic          r_tmo_flg;

  logic          w_req_i;
  logic          w_req_d;
  logic          w_expired;
  logic          w_tmo;
  logic          w_clr;
  logic          w_inc;

  logic [AW-1:2] w_adr;
  logic [3:0]    w_sel;
  logic          w_stb;
  logic          w_wre;
  logic          w_cyc;
  logic [31:0]   w_dat;

  logic [31:0]   w_i_dat;
  logic          w_i_ack;
  logic          w_i_err;
  logic [31:0]   w_d_dat;
  logic          w_d_ack;
  logic          w_d_err;

  assign w_req_i = f_req(iwb.cyc_o, iwb.stb_o);
  assign w_req_d = f_req(dwb.cyc_o, dwb.stb_o);

  // An ack in the expiring cycle wins, so the error needs a strobe left unanswered
  assign w_tmo = (r_state != IDLE) & w_stb & ~mwb.ack_i & w_expired;
  assign w_clr = (r_state == IDLE) | mwb.ack_i | w_tmo;
  assign w_inc = w_stb & ~mwb.ack_i;

  aemb2_wb_tmo #(
    .TMO (TMO)
  ) u_tmo (
    .sys_clk_i (sys_clk_i),
    .sys_rst_i (sys_rst_i),
    .clr       (w_clr),
    .inc       (w_inc),
    .expired   (w_expired)
  );

  // Arbitration state, round-robin pointer and sticky timeout flag
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_state   <= IDLE;
      r_last_i  <= 1'b1;
      r_tmo_flg <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last_i  <= w_last_i_nxt;
      r_tmo_flg <= r_tmo_flg | w_tmo;
    end
  end

  // Next state: decisions only from IDLE; a grant lasts while its cyc is held
  always_comb begin
    w_state_nxt  = r_state;
    w_last_i_nxt = r_last_i;
    case (r_state)
      IDLE: begin
        if (w_req_i && (!w_req_d || !r_last_i)) begin
          w_state_nxt  = GNT_I;
          w_last_i_nxt = 1'b1;
        end else if (w_req_d) begin
          w_state_nxt  = GNT_D;
          w_last_i_nxt = 1'b0;
        end else begin
          w_state_nxt  = IDLE;
        end
      end
      GNT_I: begin
        if (w_tmo || !iwb.cyc_o) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = GNT_I;
        end
      end
      GNT_D: begin
        if (w_tmo || !dwb.cyc_o) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = GNT_D;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Request and response steering for the granted master; everything idles at 0
  always_comb begin
    w_adr   = {(AW-2){1'b0}};
    w_sel   = 4'h0;
    w_stb   = 1'b0;
    w_wre   = 1'b0;
    w_cyc   = 1'b0;
    w_dat   = 32'h0000_0000;
    w_i_dat = 32'h0000_0000;
    w_i_ack = 1'b0;
    w_i_err = 1'b0;
    w_d_dat = 32'h0000_0000;
    w_d_ack = 1'b0;
    w_d_err = 1'b0;
    case (r_state)
      GNT_I: begin
        w_adr   = iwb.adr_o;
        w_sel   = iwb.sel_o;
        w_stb   = iwb.stb_o;
        w_wre   = iwb.wre_o;
        w_cyc   = iwb.cyc_o;
        w_dat   = iwb.dat_o;
        w_i_dat = mwb.dat_i;
        w_i_ack = mwb.ack_i;
        w_i_err = w_tmo;
      end
      GNT_D: begin
        w_adr   = dwb.adr_o;
        w_sel   = dwb.sel_o;
        w_stb   = dwb.stb_o;
        w_wre   = dwb.wre_o;
        w_cyc   = dwb.cyc_o;
        w_dat   = dwb.dat_o;
        w_d_dat = mwb.dat_i;
        w_d_ack = mwb.ack_i;
        w_d_err = w_tmo;
      end
      default: begin
        w_cyc = 1'b0;
      end
    endcase
  end

  assign mwb.adr_o = w_adr;
  assign mwb.sel_o = w_sel;
  assign mwb.stb_o = w_stb;
  assign mwb.wre_o = w_wre;
  assign mwb.cyc_o = w_cyc;
  assign mwb.dat_o = w_dat;

  assign iwb.dat_i = w_i_dat;
  assign iwb.ack_i = w_i_ack;
  assign iwb.err_i = w_i_err;
  assign dwb.dat_i = w_d_dat;
  assign dwb.ack_i = w_d_ack;
  assign dwb.err_i = w_d_err;

  assign tmo_flg_o = r_tmo_flg;

endmodule

// File: doc/aemb2_wb_sched.md
AEMB2_WB_SCHED -- requirements
Module: aemb2_wb_sched

Interface
REQ-001 The block SHALL have parameter AW, default 14: shared memory word-address MSB+1; addresses are [AW-1:2].
REQ-002 The block SHALL have parameter TMO, default 16: cycles without ack before a forced bus error, legal range 2..255.
REQ-003 sys_clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 sys_rst_i  in  1  asynchronous, active-low reset.
REQ-005 iwb_adr_o, iwb_sel_o, iwb_stb_o, iwb_wre_o, iwb_cyc_o, iwb_dat_o  in  AW-2/4/1/1/1/32  fetch master request (master-side naming).
REQ-006 iwb_dat_i, iwb_ack_i, iwb_err_i  out  32/1/1  fetch master response.
REQ-007 dwb_adr_o, dwb_sel_o, dwb_stb_o, dwb_wre_o, dwb_cyc_o, dwb_dat_o  in  AW-2/4/1/1/1/32  data master request.
REQ-008 dwb_dat_i, dwb_ack_i, dwb_err_i  out  32/1/1  data master response.
REQ-009 mwb_adr_o, mwb_sel_o, mwb_stb_o, mwb_wre_o, mwb_cyc_o, mwb_dat_o  out  AW-2/4/1/1/1/32  shared RAM port.
REQ-010 mwb_dat_i, mwb_ack_i  in  32/1  shared RAM response.
REQ-011 tmo_flg_o  out  1  sticky timeout indicator.

Function
REQ-012 States SHALL be IDLE, GNT_I, GNT_D; a request is cyc&stb of a master.
REQ-013 In IDLE with exactly one request, the next state SHALL be that master's GNT state.
REQ-014 In IDLE with both requesting, the grant SHALL go to the master not served last (round-robin); after reset, dwb wins the first tie.
REQ-015 Grant latency SHALL be exactly one cycle: request seen in IDLE at edge n -> mwb_stb_o high after edge n+1.
REQ-016 In GNT_x the mwb_* outputs SHALL be combinational copies of master x's request signals.
REQ-017 In GNT_x, mwb_dat_i SHALL route to x's dat_i and mwb_ack_i to x's ack_i; the other master's ack_i/err_i SHALL be 0 and its dat_i SHALL be 0.
REQ-018 GNT_x SHALL be held while x's cyc stays high (bus lock across multiple strobes), and SHALL return to IDLE on the edge after x's cyc goes low.
REQ-019 From IDLE, no back-to-back re-grant skips IDLE; every arbitration decision is made in IDLE.
REQ-020 In IDLE, all mwb_* outputs SHALL be 0, and mwb_ack_i SHALL be ignored.
REQ-021 The timeout counter (width 8) SHALL clear on entry to GNT_x and on every mwb_ack_i, and increment each cycle mwb_stb_o is high without ack.
REQ-022 When the counter reaches TMO-1 without ack, the block SHALL pulse x's err_i high for one cycle, set tmo_flg_o, and go to IDLE regardless of x's cyc.
REQ-023 A timeout and an ack in the same cycle SHALL resolve as ack (no error).
REQ-024 A late mwb_ack_i arriving after a timeout SHALL be discarded.
REQ-025 tmo_flg_o SHALL clear only on reset.

Reset
REQ-026 While sys_rst_i is low, state SHALL be IDLE, counter 0, and tmo_flg_o 0; the round-robin pointer SHALL favour dwb; all outputs SHALL be 0.
REQ-027 Assertion mid-transfer SHALL abort immediately; no ack or err SHALL be forwarded.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE=2'b00, GNT_I=2'b01, GNT_D=2'b10) and the TMO default.
REQ-029 The timeout counter SHALL be one sub-module, aemb2_wb_tmo (inputs clr, inc; output expired).

Verification
REQ-030 Single dwb read at 0x0040, RAM acks 1 cycle after stb -> mwb_stb_o rises 1 cycle after request, dwb_ack_i one cycle, iwb_ack_i stays 0.
REQ-031 iwb and dwb request in the same cycle after reset -> dwb granted first, iwb granted in the first IDLE after dwb drops cyc; a second tie goes to iwb.
REQ-032 dwb holds cyc across 4 strobes (burst) while iwb requests -> iwb waits all 4 acks, then is granted.
REQ-033 RAM never acks an iwb fetch, TMO=16 -> iwb_err_i pulses on the 16th stb cycle, tmo_flg_o=1, state IDLE; a late ack is not forwarded.
REQ-034 sys_rst_i driven low mid-dwb-write -> all mwb_* read 0 asynchronously, no dwb_ack_i, tmo_flg_o=0.
